montador_senha: RTL and testbench
=================================

MONTADOR_SENHA -- requirements
Module: montador_senha

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter TIMEOUT_S, default 5, inactivity timeout in seconds.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  key acceptance enable; keys are ignored while low.
REQ-006 key_valid  input  1  one-cycle strobe marking a decoded keypad press.
REQ-007 key_code  input  4  key code: 0-9 digit, 4'hA '*', 4'hB '#', all others invalid.
REQ-008 digitos_value  output  senhaPac_t (20x4 bits)  digit packet; digit[0] is the newest; unused positions are 4'hF.
REQ-009 digitos_valid  output  1  one-cycle strobe marking a completed packet.

Function
REQ-010 Hold a 20-digit buffer and a 5-bit count (0-20); digitos_value shall continuously mirror the buffer while digitos_valid is low.
REQ-011 Digit key accepted at cycle N: shift digit[i] to digit[i+1], load the key into digit[0], increment count; visible on digitos_value at N+1.
REQ-012 Digit key with count = 20: discard it; buffer and count unchanged.
REQ-013 '#' at N with count > 0: digitos_valid = 1 at N+1 with digitos_value = buffer; at N+2 buffer = {20{4'hF}}, count = 0.
REQ-014 '#' at N with count = 0: digitos_valid = 1 at N+1 with digitos_value = {20{4'hF}} (skip field).
REQ-015 '*' at N with count > 0: clear buffer to {20{4'hF}} and count to 0 at N+1; no valid strobe.
REQ-016 '*' at N with count = 0: digitos_valid = 1 at N+1 with digitos_value = {20{4'hB}} (exit/save).
REQ-017 Invalid key codes: no effect, and the timeout counter is not restarted.
REQ-018 FSM states VAZIO (count = 0), ENTRADA (count > 0), EMITE (one cycle, strobe asserted); EMITE always returns to VAZIO.
REQ-019 In EMITE, any key_valid is ignored.
REQ-020 enable low: buffer forced to {20{4'hF}}, count 0, FSM to VAZIO, timeout counter cleared, digitos_valid 0.
REQ-021 digitos_valid shall never be high on two consecutive cycles.

Reset
REQ-022 On rst: digitos_value = {20{4'hF}}, digitos_valid = 0, count = 0, FSM = VAZIO, timeout counter = 0; rst overrides all inputs, including mid-entry and during EMITE.

Configuration
REQ-023 With MONTADOR_TIMEOUT_EN defined: in ENTRADA, count cycles since the last accepted digit/'#'/'*' key.
REQ-024 With MONTADOR_TIMEOUT_EN defined: on reaching CLK_FREQ*TIMEOUT_S cycles, emit digitos_valid = 1 with {20{4'hE}} for one cycle, then clear the buffer.
REQ-025 With MONTADOR_TIMEOUT_EN defined: a key_valid in the expiry cycle wins (key is processed, counter restarts, no E packet).
REQ-026 With MONTADOR_TIMEOUT_EN undefined: no counter logic is present and a partial entry is held indefinitely.

Structure
REQ-027 senhaPac_t, the key code constants (TECLA_AST = 4'hA, TECLA_CERQ = 4'hB) and the sentinel packets (PAC_VAZIO all-F, PAC_SAIR all-B, PAC_TIMEOUT all-E) reside in the shared Tipos.sv package.
REQ-028 The timeout counter is sub-module contador_timeout (ports clk, rst, clear, run, expired).
REQ-029 contador_timeout has width $clog2(CLK_FREQ*TIMEOUT_S+1) and is instantiated only under MONTADOR_TIMEOUT_EN.

Verification
REQ-030 Keys 1,2,3,4,'#' -> single digitos_valid with digits[3:0] = 1,2,3,4 (digit[0] = 4), digits[19:4] = F; next cycle all-F.
REQ-031 '#' on empty buffer -> one strobe with {20{4'hF}}; '*' on empty buffer -> one strobe with {20{4'hB}}.
REQ-032 Keys 7,8,'*','#' -> no strobe on '*', buffer cleared; then strobe with all-F.
REQ-033 22 digit keys 0..9 repeating, then '#' -> strobe with the first 20 digits only (digit[0] = 9, digit[19] = 0).
REQ-034 With MONTADOR_TIMEOUT_EN defined and CLK_FREQ = 10, TIMEOUT_S = 1: key 5 then idle -> all-E strobe exactly 10 cycles after the key, buffer all-F afterwards; repeat with key 6 arriving in the expiry cycle -> no E strobe, buffer = 6,5.
REQ-035 Keys 3,9 then rst for one cycle, and separately keys 3,9 then enable low -> digitos_value all-F, no strobe, subsequent '#' emits all-F.

Source files
------------

// File: rtl/Tipos.sv
// Shared types and constants for the password assembler: packet type, key codes,
// sentinel packets and FSM states.
package Tipos;

    localparam int NUM_DIGITOS = 20;

    typedef logic [NUM_DIGITOS-1:0][3:0] senhaPac_t;

    localparam logic [3:0] TECLA_AST  = 4'hA;
    localparam logic [3:0] TECLA_CERQ = 4'hB;

    localparam senhaPac_t PAC_VAZIO   = {NUM_DIGITOS{4'hF}};
    localparam senhaPac_t PAC_SAIR    = {NUM_DIGITOS{4'hB}};
    localparam senhaPac_t PAC_TIMEOUT = {NUM_DIGITOS{4'hE}};

    typedef enum logic [1:0] {
        VAZIO   = 2'd0,
        ENTRADA = 2'd1,
        EMITE   = 2'd2
    } estado_t;

    function automatic logic e_digito(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity counter for the password assembler; only instantiated when
// MONTADOR_TIMEOUT_EN is defined.
module contador_timeout #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TIMEOUT_S = 5,
    localparam int LIMITE   = CLK_FREQ * TIMEOUT_S,
    localparam int W        = $clog2(LIMITE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [W-1:0] LIM  = W'(LIMITE);
    localparam logic [W-1:0] LAST = W'(LIMITE - 1);

    logic [W-1:0] cnt_q;

    // Clearing loads 1 because the clearing cycle (the accepted key) already counts
    // as the first elapsed cycle; saturation keeps expiry sticky if a key is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= W'(1);
        end else if (run && cnt_q < LIM) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired = run && (cnt_q >= LAST);

endmodule

// File: rtl/montador_senha.sv
// Keypad password assembler: collects up to 20 digits and emits a packet on '#'.
// Optional inactivity timeout enabled by defining MONTADOR_TIMEOUT_EN.
module montador_senha
    import Tipos::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TIMEOUT_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    estado_t    state_q, state_d;
    senhaPac_t  buf_q, buf_d;
    senhaPac_t  emit_q, emit_d;
    logic [4:0] count_q, count_d;
    logic       key_acc;
    logic       expired;

`ifdef MONTADOR_TIMEOUT_EN
    logic timer_clear;
    logic timer_run;

    assign timer_clear = !enable || key_acc || (state_q != ENTRADA);
    assign timer_run   = enable && (state_q == ENTRADA);

    contador_timeout #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );
`else
    logic unused_cfg;

    assign expired    = 1'b0;
    assign unused_cfg = ^{CLK_FREQ, TIMEOUT_S, key_acc};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VAZIO;
            buf_q   <= PAC_VAZIO;
            emit_q  <= PAC_VAZIO;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            emit_q  <= emit_d;
            count_q <= count_d;
        end
    end

    // A recognised key always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        emit_d  = emit_q;
        count_d = count_q;
        key_acc = 1'b0;

        if (!enable) begin
            state_d = VAZIO;
            buf_d   = PAC_VAZIO;
            count_d = '0;
        end else if (state_q == EMITE) begin
            state_d = VAZIO;
        end else if (key_valid && e_digito(key_code)) begin
            if (count_q < 5'(NUM_DIGITOS)) begin
                key_acc = 1'b1;
                buf_d   = {buf_q[NUM_DIGITOS-2:0], key_code};
                count_d = count_q + 5'd1;
                state_d = ENTRADA;
            end
        end else if (key_valid && key_code == TECLA_CERQ) begin
            key_acc = 1'b1;
            emit_d  = (count_q == 5'd0) ? PAC_VAZIO : buf_q;
            buf_d   = PAC_VAZIO;
            count_d = '0;
            state_d = EMITE;
        end else if (key_valid && key_code == TECLA_AST) begin
            key_acc = 1'b1;
            buf_d   = PAC_VAZIO;
            count_d = '0;
            if (count_q == 5'd0) begin
                emit_d  = PAC_SAIR;
                state_d = EMITE;
            end else begin
                state_d = VAZIO;
            end
        end else if (state_q == ENTRADA && expired) begin
            emit_d  = PAC_TIMEOUT;
            buf_d   = PAC_VAZIO;
            count_d = '0;
            state_d = EMITE;
        end
    end

    assign digitos_valid = (state_q == EMITE);
    assign digitos_value = digitos_valid ? emit_q : buf_q;

endmodule

// File: tb/tb_montador_senha.sv
// Self-checking bench for montador_senha: table-driven vectors feeding a scoreboard,
// plus hand-written sequences for overflow and (when MONTADOR_TIMEOUT_EN is set) timeout.
module tb_montador_senha;
    import Tipos::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    senhaPac_t  digitos_value;
    logic       digitos_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic       kv;
        logic [3:0] code;
        logic       ev;
        senhaPac_t  ex;
    } vec_t;

    typedef struct {
        int        due;
        int        tag;
        logic      ev;
        senhaPac_t ex;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    montador_senha #(
        .CLK_FREQ  (10),
        .TIMEOUT_S (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    function automatic senhaPac_t tl(input logic [31:0] d, input int n);
        senhaPac_t p = PAC_VAZIO;
        for (int i = 0; i < n; i++) p[i] = d[i*4 +: 4];
        return p;
    endfunction

    task automatic addv(input logic r, input logic e, input logic kv, input logic [3:0] code,
                        input logic ev, input senhaPac_t ex);
        vec_t v;
        v.r = r; v.e = e; v.kv = kv; v.code = code; v.ev = ev; v.ex = ex;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs; the expectation applies to the following cycle.
    task automatic applyStimulus(input logic r, input logic e, input logic kv, input logic [3:0] code,
                                 input bit chk, input logic ev, input senhaPac_t ex, input int tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; enable = e; key_valid = kv; key_code = code;
        if (chk) begin
            x.due = cyc + 1; x.tag = tag; x.ev = ev; x.ex = ex;
            sb.push_back(x);
        end
    endtask

    task automatic checkOutput(input exp_t x);
        checks++;
        if (digitos_valid !== x.ev) begin
            failures++;
            $display("[TB] FAIL valid tag=%0d cyc=%0d got=%b want=%b", x.tag, cyc, digitos_valid, x.ev);
        end
        checks++;
        if (digitos_value !== x.ex) begin
            failures++;
            $display("[TB] FAIL value tag=%0d cyc=%0d got=%h want=%h", x.tag, cyc, digitos_value, x.ex);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // reset overrides a key press
        addv(1, 1, 1, 4'h5, 0, PAC_VAZIO);
        addv(1, 0, 0, 4'h0, 0, PAC_VAZIO);
        // 1,2,3,4,#
        addv(0, 1, 1, 4'h1, 0, tl(32'h1, 1));
        addv(0, 1, 1, 4'h2, 0, tl(32'h12, 2));
        addv(0, 1, 1, 4'h3, 0, tl(32'h123, 3));
        addv(0, 1, 1, 4'h4, 0, tl(32'h1234, 4));
        addv(0, 1, 1, TECLA_CERQ, 1, tl(32'h1234, 4));
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // '#' and '*' on empty buffer
        addv(0, 1, 1, TECLA_CERQ, 1, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        addv(0, 1, 1, TECLA_AST, 1, PAC_SAIR);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // 7,8,*,#
        addv(0, 1, 1, 4'h7, 0, tl(32'h7, 1));
        addv(0, 1, 1, 4'h8, 0, tl(32'h78, 2));
        addv(0, 1, 1, TECLA_AST, 0, PAC_VAZIO);
        addv(0, 1, 1, TECLA_CERQ, 1, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // invalid codes, unstrobed code, key during EMITE
        addv(0, 1, 1, 4'h5, 0, tl(32'h5, 1));
        addv(0, 1, 1, 4'hC, 0, tl(32'h5, 1));
        addv(0, 1, 0, 4'h3, 0, tl(32'h5, 1));
        addv(0, 1, 1, 4'hF, 0, tl(32'h5, 1));
        addv(0, 1, 1, TECLA_CERQ, 1, tl(32'h5, 1));
        addv(0, 1, 1, 4'h9, 0, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // 3,9 then enable low
        addv(0, 1, 1, 4'h3, 0, tl(32'h3, 1));
        addv(0, 1, 1, 4'h9, 0, tl(32'h39, 2));
        addv(0, 0, 0, 4'h0, 0, PAC_VAZIO);
        addv(0, 0, 1, 4'h4, 0, PAC_VAZIO);
        addv(0, 1, 1, TECLA_CERQ, 1, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // 3,9 then rst
        addv(0, 1, 1, 4'h3, 0, tl(32'h3, 1));
        addv(0, 1, 1, 4'h9, 0, tl(32'h39, 2));
        addv(1, 1, 0, 4'h0, 0, PAC_VAZIO);
        addv(0, 1, 1, TECLA_CERQ, 1, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);
        // rst during EMITE
        addv(0, 1, 1, 4'h1, 0, tl(32'h1, 1));
        addv(0, 1, 1, TECLA_CERQ, 1, tl(32'h1, 1));
        addv(1, 1, 1, 4'h2, 0, PAC_VAZIO);
        addv(0, 1, 0, 4'h0, 0, PAC_VAZIO);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].kv, vecs[i].code, 1'b1,
                          vecs[i].ev, vecs[i].ex, i);
        end

        // 22 digits 0..9 repeating: only the first 20 are kept
        for (int i = 0; i < 22; i++) begin
            applyStimulus(0, 1, 1, 4'(i % 10), (i >= 19), 0, 80'h01234567890123456789, 100 + i);
        end
        applyStimulus(0, 1, 1, TECLA_CERQ, 1, 1, 80'h01234567890123456789, 130);
        applyStimulus(0, 1, 0, 4'h0, 1, 0, PAC_VAZIO, 131);

`ifdef MONTADOR_TIMEOUT_EN
        // key 5 then idle: E packet exactly 10 cycles after the key
        applyStimulus(0, 1, 1, 4'h5, 1, 0, tl(32'h5, 1), 200);
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 4'h0, 1, 0, tl(32'h5, 1), 200 + i);
        applyStimulus(0, 1, 0, 4'h0, 1, 1, PAC_TIMEOUT, 209);
        applyStimulus(0, 1, 0, 4'h0, 1, 0, PAC_VAZIO, 210);
        applyStimulus(0, 1, 0, 4'h0, 1, 0, PAC_VAZIO, 211);
        // key 6 in the expiry cycle wins
        applyStimulus(0, 1, 1, 4'h5, 1, 0, tl(32'h5, 1), 300);
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 4'h0, 1, 0, tl(32'h5, 1), 300 + i);
        applyStimulus(0, 1, 1, 4'h6, 1, 0, tl(32'h56, 2), 309);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'h0, 1, 0, tl(32'h56, 2), 310 + i);
        applyStimulus(0, 1, 1, TECLA_AST, 1, 0, PAC_VAZIO, 320);
`endif

        applyStimulus(0, 1, 0, 4'h0, 0, 0, PAC_VAZIO, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
